fifo_pkt_axi_to_classic: RTL and testbench
==========================================

FIFO_PKT_AXI_TO_CLASSIC -- requirements
Module: fifo_pkt_axi_to_classic

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (legal 1..256).
REQ-002 Parameter SIZE, default 9, log2 of storage depth; DEPTH = 2^SIZE words (legal 2..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous, active-high flush; same effect as reset.
REQ-006 tdata_i  input  WIDTH  AXI-stream data in.
REQ-007 tlast_i  input  1  AXI-stream end-of-packet marker.
REQ-008 tvalid_i  input  1  upstream has a word.
REQ-009 tready_i  output  1  block can accept a word.
REQ-010 dataout  output  WIDTH  classic-side data out.
REQ-011 eop_o  output  1  stored tlast of the word on dataout.
REQ-012 src_rdy_o  output  1  dataout/eop_o valid.
REQ-013 dst_rdy_i  input  1  downstream accepts the word.
REQ-014 space  output  16  free word slots.
REQ-015 occupied  output  16  stored words, including the output register.
REQ-016 pkt_count  output  16  complete packets held (accepted tlast words not yet read).
REQ-017 oversize  output  1  one-cycle pulse: forced release of an incomplete packet.

Function
REQ-018 Input transfer = tvalid_i & tready_i; output transfer = src_rdy_o & dst_rdy_i.
REQ-019 tready_i = (occupied != DEPTH); it has no combinational dependence on dst_rdy_i or tvalid_i.
REQ-020 At full, an output transfer in the same cycle does not enable a write; tready_i rises the following cycle.
REQ-021 Storage: DEPTH-entry array plus one output register; the output register counts toward DEPTH.
REQ-022 Read and write pointers are SIZE bits and wrap from DEPTH-1 to 0 with no lost or duplicated word.
REQ-023 Latency: a word accepted into an empty block at edge N appears on src_rdy_o/dataout after edge N+2.
REQ-024 Throughput: sustained one word per cycle in and out with both sides always ready.
REQ-025 Output register refills in the same cycle as an output transfer when the array is non-empty, with no bubble.
REQ-026 dataout and eop_o hold stable while src_rdy_o=1 and dst_rdy_i=0.
REQ-027 occupied = writes minus reads; space = DEPTH - occupied; both are zero-extended to 16 bits and updated one cycle after the transfer.
REQ-028 pkt_count increments on an input transfer with tlast_i=1, decrements on an output transfer with eop_o=1, and is unchanged when both occur in one cycle.
REQ-029 Word order and tlast position are preserved exactly.

Reset
REQ-030 On reset or clear: tready_i=0 in that cycle, then 1.
REQ-031 On reset or clear: src_rdy_o=0, eop_o=0, dataout=0, occupied=0, space=DEPTH, pkt_count=0, oversize=0, pointers=0.
REQ-032 Reset or clear asserted mid-packet discards all stored words, including the partial packet; the next accepted word is treated as a packet start.
REQ-033 Reset has priority over any simultaneous transfer; the transfer is dropped.

Configuration
REQ-034 Macro FIFO_PKT_AXI_TO_CLASSIC_PKT_MODE_EN selects packet mode.
REQ-035 With the macro defined, src_rdy_o = output-register-valid & (pkt_count != 0 | release); words are never presented until their packet's tlast is stored.
REQ-036 With the macro defined, release sets when occupied == DEPTH and pkt_count == 0.
REQ-037 With the macro defined, oversize pulses for one cycle when release sets.
REQ-038 With the macro defined, release clears after an output transfer with eop_o=1, or on reset or clear.
REQ-039 Without the macro, src_rdy_o = output-register-valid and oversize is tied 0; pkt_count still counts.

Verification
REQ-040 SIZE=4, no macro: write 0x01..0x10 back-to-back with dst_rdy_i=0 -> tready_i=0 after the 16th accept; occupied=16; space=0; dataout=0x01.
REQ-041 Full at SIZE=4, then dst_rdy_i=1 with tvalid_i=1 -> no write in the read cycle; tready_i=1 next cycle; output order 0x01..0x10 with no gaps.
REQ-042 Stream 40 words with tlast on every 8th, random tvalid_i/dst_rdy_i at 50% -> identical data/eop sequence out; pkt_count returns to 0.
REQ-043 Macro defined: write 3 words without tlast -> src_rdy_o stays 0; write a 4th with tlast -> src_rdy_o=1 two cycles later; pkt_count=1.
REQ-044 Macro defined, SIZE=4: 16 words without tlast -> oversize pulses once; all 16 words drain.
REQ-045 Assert clear after 5 words of a packet -> occupied=0, space=DEPTH, src_rdy_o=0 next cycle; the following packet passes intact.

Source files
------------

// File: rtl/fifo_pkt_axi_to_classic.sv
// AXI-stream in / classic src_rdy/dst_rdy out FIFO with packet counting.
// Define FIFO_PKT_AXI_TO_CLASSIC_PKT_MODE_EN to hold words until their packet's tlast is stored.
module fifo_pkt_axi_to_classic #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] tdata_i,
  input  logic             tlast_i,
  input  logic             tvalid_i,
  output logic             tready_i,
  output logic [WIDTH-1:0] dataout,
  output logic             eop_o,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic [15:0]      pkt_count,
  output logic             oversize
);

  localparam int          DEPTH   = 1 << SIZE;
  localparam int          CW      = SIZE + 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  logic             rst;
  logic             wr_xfer;
  logic             rd_xfer;
  logic             load;

  // Input stage: one register ahead of the array gives the two-edge latency.
  logic             in_vld_q;
  logic [WIDTH-1:0] in_data_q;
  logic             in_last_q;

  logic [WIDTH:0]   mem [DEPTH];
  logic [SIZE-1:0]  wr_ptr_q;
  logic [SIZE-1:0]  rd_ptr_q;
  logic [CW-1:0]    arr_cnt_q;
  logic [CW-1:0]    arr_cnt_d;

  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;

  logic             tready_q;
  logic [15:0]      occ_q;
  logic [15:0]      occ_d;
  logic [15:0]      pkt_q;
  logic [15:0]      pkt_d;

  assign rst     = reset | clear;
  assign wr_xfer = tvalid_i & tready_q;
  assign rd_xfer = src_rdy_o & dst_rdy_i;
  // Output register refills from the array whenever it is empty or being read.
  assign load    = (arr_cnt_q != '0) & (~out_vld_q | rd_xfer);

  always_comb begin
    occ_d     = occ_q + 16'(wr_xfer) - 16'(rd_xfer);
    pkt_d     = pkt_q + 16'(wr_xfer & tlast_i) - 16'(rd_xfer & out_last_q);
    arr_cnt_d = arr_cnt_q + CW'(in_vld_q) - CW'(load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q   <= 1'b0;
      in_data_q  <= '0;
      in_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      arr_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      tready_q   <= 1'b0;
      occ_q      <= '0;
      pkt_q      <= '0;
    end else begin
      in_vld_q <= wr_xfer;
      if (wr_xfer) begin
        in_data_q <= tdata_i;
        in_last_q <= tlast_i;
      end
      if (in_vld_q) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_vld_q  <= 1'b1;
        out_data_q <= mem[rd_ptr_q][WIDTH-1:0];
        out_last_q <= mem[rd_ptr_q][WIDTH];
      end else if (rd_xfer) begin
        out_vld_q <= 1'b0;
      end
      arr_cnt_q <= arr_cnt_d;
      occ_q     <= occ_d;
      pkt_q     <= pkt_d;
      tready_q  <= (occ_d != DEPTH16);
    end
  end

  // The array never overflows: total occupancy including both stages is capped at DEPTH.
  always_ff @(posedge clk) begin
    if (in_vld_q && !rst) begin
      mem[wr_ptr_q] <= {in_last_q, in_data_q};
    end
  end

`ifdef FIFO_PKT_AXI_TO_CLASSIC_PKT_MODE_EN
  logic rel_q;
  logic oversize_q;
  logic rel_set;

  // Full with no complete packet would deadlock; force the partial packet out.
  assign rel_set = ~rel_q & (occ_q == DEPTH16) & (pkt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rel_q      <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      oversize_q <= rel_set;
      if (rel_set) begin
        rel_q <= 1'b1;
      end else if (rd_xfer && out_last_q) begin
        rel_q <= 1'b0;
      end
    end
  end

  assign src_rdy_o = out_vld_q & ((pkt_q != '0) | rel_q);
  assign oversize  = oversize_q;
`else
  assign src_rdy_o = out_vld_q;
  assign oversize  = 1'b0;
`endif

  assign tready_i  = tready_q;
  assign dataout   = out_data_q;
  assign eop_o     = out_last_q;
  assign occupied  = occ_q;
  assign space     = DEPTH16 - occ_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_fifo_pkt_axi_to_classic.sv
// Directed + random bench for fifo_pkt_axi_to_classic (SIZE=4, WIDTH=8) with a scoreboard monitor.
module tb_fifo_pkt_axi_to_classic;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [7:0]  tdata;
  logic        tlast, tvalid, tready_i;
  logic [7:0]  dataout;
  logic        eop_o, src_rdy_o, dst_rdy;
  logic [15:0] space, occupied, pkt_count;
  logic        oversize;

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb[$];
  int          m_occ = 0;
  int          m_pkt = 0;
  logic        m_trdy = 1'b0;
  logic        armed = 1'b0;
  logic        hold = 1'b0;
  logic [8:0]  hold_word = '0;
  logic        in_x, out_x;
  int          n_out = 0;
  int          ovs_cnt = 0;

  fifo_pkt_axi_to_classic #(.WIDTH(8), .SIZE(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .tdata_i(tdata), .tlast_i(tlast), .tvalid_i(tvalid), .tready_i(tready_i),
    .dataout(dataout), .eop_o(eop_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy),
    .space(space), .occupied(occupied), .pkt_count(pkt_count), .oversize(oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: transfers are decided by the values held between negedge and the next posedge.
  always @(negedge clk) begin
    if (reset || clear) begin
      sb.delete();
      m_occ  = 0;
      m_pkt  = 0;
      m_trdy = 1'b0;
      armed  = 1'b1;
      hold   = 1'b0;
    end else if (armed) begin
      chk("tready", tready_i, m_trdy);
      chk("occupied", occupied, m_occ);
      chk("space", space, 16 - m_occ);
      chk("pkt_count", pkt_count, m_pkt);
      if (hold) begin
        chk("hold_src_rdy", src_rdy_o, 1);
        chk("hold_word", {eop_o, dataout}, hold_word);
      end
`ifdef FIFO_PKT_AXI_TO_CLASSIC_PKT_MODE_EN
      if (oversize === 1'b1) ovs_cnt++;
`else
      chk("oversize_tied", oversize, 0);
`endif
      in_x  = tvalid && tready_i;
      out_x = src_rdy_o && dst_rdy;
      if (out_x) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("sb_word", {eop_o, dataout}, sb[0]);
          if (sb[0][8]) m_pkt--;
          void'(sb.pop_front());
          n_out++;
          m_occ--;
        end
      end
      if (in_x) begin
        sb.push_back({tlast, tdata});
        m_occ++;
        if (tlast) m_pkt++;
      end
      m_trdy    = (m_occ != 16);
      hold      = src_rdy_o && !dst_rdy;
      hold_word = {eop_o, dataout};
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input string tag);
    int n = 0;
    @(posedge clk); #1;
    tdata = d; tlast = l; tvalid = 1'b1;
    @(negedge clk);
    while (!tready_i && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, tready_i, 1);
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(posedge clk); #1;
    tvalid = 1'b0; dst_rdy = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((occupied != 0 || sb.size() != 0) && n < 200);
    chk({tag, "_occ"}, occupied, 0);
    chk({tag, "_sb"}, sb.size(), 0);
    dst_rdy = 1'b0;
  endtask

  initial begin
    int idx;
    int out0;
    reset = 1'b1; clear = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; dst_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tready", tready_i, 0);
    chk("rst_src_rdy", src_rdy_o, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_eop", eop_o, 0);
    chk("rst_occupied", occupied, 0);
    chk("rst_space", space, 16);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_oversize", oversize, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_tready_rise", tready_i, 1);

    // Latency into an empty block: visible after the second edge past the accept.
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = 8'hA5; tlast = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    @(negedge clk); chk("lat_n0", src_rdy_o, 0);
    @(negedge clk); chk("lat_n1", src_rdy_o, 0);
    @(negedge clk); chk("lat_n2", src_rdy_o, 1);
    chk("lat_data", dataout, 8'hA5);
    drain("lat_drain");

    // Fill to full back-to-back with the reader stalled.
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      tvalid = 1'b1; tdata = 8'(i); tlast = (i == 16);
      @(negedge clk); chk("fill_tready", tready_i, 1);
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    @(negedge clk);
    chk("full_tready", tready_i, 0);
    chk("full_occupied", occupied, 16);
    chk("full_space", space, 0);
    @(negedge clk);
    @(negedge clk);
    chk("full_dataout", dataout, 8'h01);
    chk("full_src_rdy", src_rdy_o, 1);

    // Read at full with a word pending: no write that cycle, tready returns next cycle.
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = 8'h11; tlast = 1'b1; dst_rdy = 1'b1;
    @(negedge clk);
    chk("rdfull_tready", tready_i, 0);
    chk("rdfull_src_rdy", src_rdy_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdfull_tready_rise", tready_i, 1);
    chk("rdfull_no_gap1", src_rdy_o, 1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    for (int k = 2; k < 16; k++) begin
      @(negedge clk); chk("rdfull_no_gap", src_rdy_o, 1);
      @(posedge clk); #1;
    end
    drain("full_drain");

    // Random stream: 40 words, tlast every 8th, 50% valid/ready.
    idx = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000 && idx < 40; cyc++) begin
      tvalid  = 1'($urandom_range(0, 1));
      tdata   = 8'($urandom);
      tlast   = (idx % 8 == 7);
      dst_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (tvalid && tready_i) idx++;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    chk("stream_count", idx, 40);
    drain("stream_drain");
    chk("stream_pkt_zero", pkt_count, 0);

    // Clear mid-packet, with a word offered during the clear cycle.
    @(posedge clk); #1;
    dst_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1; tdata = 8'(8'h20 + i); tlast = 1'b0;
      @(negedge clk); chk("clr_fill_tready", tready_i, 1);
      @(posedge clk); #1;
    end
    tdata = 8'hEE; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; tvalid = 1'b0;
    @(negedge clk);
    chk("clr_occupied", occupied, 0);
    chk("clr_space", space, 16);
    chk("clr_src_rdy", src_rdy_o, 0);
    chk("clr_tready", tready_i, 0);
    out0 = n_out;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), (i == 3), "clr_next");
    drain("clr_drain");
    chk("clr_next_count", n_out - out0, 4);

`ifdef FIFO_PKT_AXI_TO_CLASSIC_PKT_MODE_EN
    // Words withheld until tlast is stored.
    dst_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 1'b0, "pkt_part");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("pkt_withheld", src_rdy_o, 0);
    end
    send(8'h43, 1'b1, "pkt_last");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pkt_release_src_rdy", src_rdy_o, 1);
    chk("pkt_release_count", pkt_count, 1);
    drain("pkt_drain");

    // Oversize: a full block with no tlast is force-released once.
    ovs_cnt = 0;
    for (int i = 0; i < 16; i++) send(8'(8'h50 + i), 1'b0, "ovs_fill");
    repeat (4) @(negedge clk);
    out0 = n_out;
    drain("ovs_drain");
    chk("ovs_drained", n_out - out0, 16);
    chk("ovs_pulses", ovs_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
